// File: rtl/vc_elastic_pipe.sv
// vc_elastic_pipe: valid/ready register chain of p_nstages stages with bubble collapsing.
// Defining VC_ELASTIC_PIPE_FLUSH_EN adds a flush input that empties the chain at a clock edge.
module vc_elastic_pipe #(
   parameter int p_nbits = 32,
   parameter int p_nstages = 2,
   parameter logic [p_nbits-1:0] p_reset_value = '0
) (
   input  logic                               clk,
   input  logic                               reset,
`ifdef VC_ELASTIC_PIPE_FLUSH_EN
   input  logic                               flush,
`endif
   input  logic                               in_val,
   output logic                               in_rdy,
   input  logic [p_nbits-1:0]                 in_msg,
   output logic                               out_val,
   input  logic                               out_rdy,
   output logic [p_nbits-1:0]                 out_msg,
   output logic [$clog2(p_nstages+1)-1:0]     occupancy
);

   localparam int OccBits = $clog2(p_nstages+1);

   logic                 flushActive;
   logic [p_nstages-1:0] val;
   logic [p_nbits-1:0]   data  [p_nstages];
   logic [p_nstages-1:0] rdy;
   logic [p_nstages-1:0] upVal;
   logic [p_nbits-1:0]   upMsg [p_nstages];
   logic                 tailFull;

`ifdef VC_ELASTIC_PIPE_FLUSH_EN
   assign flushActive = flush;
`else
   assign flushActive = 1'b0;
`endif

   assign upVal[0] = in_val;
   assign upMsg[0] = in_msg;
   for (genvar i = 1; i < p_nstages; i++) begin : g_upstream
      assign upVal[i] = val[i-1];
      assign upMsg[i] = data[i-1];
   end

   // A stage can load unless it and every stage after it are full with the consumer stalled.
   always_comb begin
      tailFull = 1'b1;
      for (int i = 0; i < p_nstages; i++) begin
         tailFull = 1'b1;
         for (int j = i; j < p_nstages; j++) begin
            tailFull = tailFull & val[j];
         end
         rdy[i] = out_rdy | ~tailFull;
      end
   end

   always_comb begin
      occupancy = '0;
      for (int i = 0; i < p_nstages; i++) begin
         occupancy = occupancy + OccBits'(val[i]);
      end
   end

   assign in_rdy  = rdy[0] & ~flushActive;
   assign out_val = val[p_nstages-1] & ~flushActive;
   assign out_msg = data[p_nstages-1];

   // Data only moves when a valid message arrives, so an empty stage keeps its last value.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         val <= '0;
         for (int i = 0; i < p_nstages; i++) begin
            data[i] <= p_reset_value;
         end
      end else if (flushActive) begin
         val <= '0;
      end else begin
         for (int i = 0; i < p_nstages; i++) begin
            if (rdy[i]) begin
               val[i] <= upVal[i];
               if (upVal[i]) begin
                  data[i] <= upMsg[i];
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_vc_elastic_pipe.sv
// tb_vc_elastic_pipe: randomized and directed bench for vc_elastic_pipe (8-bit, 3 stages).
// The reference is a conveyor model: a queue of messages each tagged with its stage position.
module tb_vc_elastic_pipe;

   localparam int N = 3;
   localparam int W = 8;
   localparam logic [W-1:0] RV = 8'hA5;

   logic         clk;
   logic         reset;
   logic         flush;
   logic         in_val;
   logic         in_rdy;
   logic [W-1:0] in_msg;
   logic         out_val;
   logic         out_rdy;
   logic [W-1:0] out_msg;
   logic [1:0]   occupancy;

   int testsRun = 0;
   int testsFailed = 0;
   int cycle = 0;

   logic [W-1:0] mMsg[$];
   int           mPos[$];
   logic [W-1:0] mLastEnd = RV;

   logic         expInRdy;
   logic         expOutVal;
   logic [W-1:0] expOutMsg;
   int           expOcc;

   vc_elastic_pipe #(.p_nbits(W), .p_nstages(N), .p_reset_value(RV)) dut (
      .clk(clk),
      .reset(reset),
`ifdef VC_ELASTIC_PIPE_FLUSH_EN
      .flush(flush),
`endif
      .in_val(in_val),
      .in_rdy(in_rdy),
      .in_msg(in_msg),
      .out_val(out_val),
      .out_rdy(out_rdy),
      .out_msg(out_msg),
      .occupancy(occupancy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic predict();
      expOcc    = mMsg.size();
      expInRdy  = ((expOcc < N) || out_rdy) && !flush;
      expOutVal = ((mMsg.size() > 0) ? (mPos[0] == N-1) : 1'b0) && !flush;
      expOutMsg = mLastEnd;
   endtask

   // Every message steps one stage per edge unless the stage ahead of it stays occupied.
   task automatic advance();
      logic         acc;
      logic         drn;
      logic [W-1:0] m;
      predict();
      acc = in_val && expInRdy;
      drn = expOutVal && out_rdy;
      m   = in_msg;
      @(posedge clk);
      cycle++;
      if (reset || flush) begin
         mMsg.delete();
         mPos.delete();
         if (reset) mLastEnd = RV;
      end else begin
         if (drn) begin
            void'(mMsg.pop_front());
            void'(mPos.pop_front());
         end
         for (int k = 0; k < mPos.size(); k++) begin
            int lim;
            int np;
            lim = (k == 0) ? N-1 : mPos[k-1] - 1;
            np  = (mPos[k] + 1 < lim) ? mPos[k] + 1 : lim;
            if (np == N-1 && mPos[k] != N-1) mLastEnd = mMsg[k];
            mPos[k] = np;
         end
         if (acc) begin
            mMsg.push_back(m);
            mPos.push_back(0);
            if (N == 1) mLastEnd = m;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      in_val = 1'b0; out_rdy = 1'b0; in_msg = '0; flush = 1'b0;
      reset = 1'b0;
      #1 reset = 1'b1;
      #1;
      testsRun++;
      if (out_val !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_out_val: got %b expected 0", out_val); end
      testsRun++;
      if (out_msg !== RV) begin testsFailed++; $display("[TB] FAIL reset_out_msg: got %h expected %h", out_msg, RV); end
      testsRun++;
      if (occupancy !== 2'd0) begin testsFailed++; $display("[TB] FAIL reset_occ: got %0d expected 0", occupancy); end
      testsRun++;
      if (in_rdy !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_in_rdy: got %b expected 1", in_rdy); end
      in_val = 1'b1; in_msg = 8'h77;
      repeat (2) @(posedge clk);
      #1;
      testsRun++;
      if (in_rdy !== 1'b1 || out_val !== 1'b0) begin
         testsFailed++;
         $display("[TB] FAIL reset_hold: got in_rdy=%b out_val=%b expected 1/0", in_rdy, out_val);
      end
      in_val = 1'b0;
      reset = 1'b0;
      mMsg.delete(); mPos.delete(); mLastEnd = RV;
   endtask

   task automatic test_streaming();
      logic [W-1:0] got[$];
      int  nextIdx = 1;
      int  accEdge = -1;
      int  drnEdge = -1;
      int  firstOut = -1;
      int  lastOut = -1;
      int  iter = 0;
      logic acc;
      out_rdy = 1'b1;
      while (got.size() < 8 && iter < 30) begin
         in_val = (nextIdx <= 8);
         in_msg = W'(nextIdx);
         @(negedge clk);
         predict();
         testsRun++;
         if (in_rdy !== 1'b1) begin testsFailed++; $display("[TB] FAIL stream_in_rdy: got %b expected 1", in_rdy); end
         testsRun++;
         if (out_val !== expOutVal) begin testsFailed++; $display("[TB] FAIL stream_out_val: got %b expected %b", out_val, expOutVal); end
         if (in_val && in_rdy && nextIdx == 1) accEdge = cycle + 1;
         if (out_val === 1'b1) begin
            testsRun++;
            if (out_msg !== expOutMsg) begin testsFailed++; $display("[TB] FAIL stream_out_msg: got %h expected %h", out_msg, expOutMsg); end
            if (out_msg === 8'h01) drnEdge = cycle + 1;
            if (firstOut < 0) firstOut = cycle + 1;
            lastOut = cycle + 1;
            got.push_back(out_msg);
         end
         acc = in_val && in_rdy;
         advance();
         if (acc) nextIdx++;
         iter++;
      end
      in_val = 1'b0;
      testsRun++;
      if (got.size() != 8) begin
         testsFailed++;
         $display("[TB] FAIL stream_count: got %0d expected 8", got.size());
      end else begin
         for (int i = 0; i < 8; i++) begin
            testsRun++;
            if (got[i] !== W'(i + 1)) begin testsFailed++; $display("[TB] FAIL stream_order: got %h expected %h", got[i], W'(i + 1)); end
         end
      end
      testsRun++;
      if (drnEdge - accEdge != 3) begin testsFailed++; $display("[TB] FAIL stream_latency: got %0d expected 3", drnEdge - accEdge); end
      testsRun++;
      if (lastOut - firstOut != 7) begin testsFailed++; $display("[TB] FAIL stream_rate: got %0d expected 7", lastOut - firstOut); end
   endtask

   task automatic test_backpressure();
      logic [W-1:0] got[$];
      int  sent = 0;
      int  iter = 0;
      logic acc;
      out_rdy = 1'b0;
      for (int c = 0; c < 6; c++) begin
         in_val = 1'b1;
         in_msg = 8'h10 + W'(sent);
         @(negedge clk);
         predict();
         testsRun++;
         if (in_rdy !== expInRdy) begin testsFailed++; $display("[TB] FAIL bp_fill_in_rdy: got %b expected %b", in_rdy, expInRdy); end
         acc = in_val && in_rdy;
         advance();
         if (acc) sent++;
      end
      in_val = 1'b1;
      in_msg = 8'h10 + W'(sent);
      @(negedge clk);
      testsRun++;
      if (sent != 3) begin testsFailed++; $display("[TB] FAIL bp_accepted: got %0d expected 3", sent); end
      testsRun++;
      if (occupancy !== 2'd3) begin testsFailed++; $display("[TB] FAIL bp_occ: got %0d expected 3", occupancy); end
      testsRun++;
      if (in_rdy !== 1'b0) begin testsFailed++; $display("[TB] FAIL bp_full_in_rdy: got %b expected 0", in_rdy); end
      out_rdy = 1'b1;
      #1;
      testsRun++;
      if (in_rdy !== 1'b1 || out_val !== 1'b1 || out_msg !== 8'h10) begin
         testsFailed++;
         $display("[TB] FAIL bp_swap: got in_rdy=%b out_val=%b out_msg=%h expected 1/1/10", in_rdy, out_val, out_msg);
      end
      while (got.size() < 4 && iter < 12) begin
         if (iter > 0) begin
            in_val = (sent < 4);
            in_msg = 8'h10 + W'(sent);
            @(negedge clk);
         end
         predict();
         testsRun++;
         if (out_val !== expOutVal) begin testsFailed++; $display("[TB] FAIL bp_out_val: got %b expected %b", out_val, expOutVal); end
         if (out_val === 1'b1) got.push_back(out_msg);
         acc = in_val && in_rdy;
         advance();
         if (acc) sent++;
         iter++;
      end
      in_val = 1'b0;
      testsRun++;
      if (got.size() != 4) begin
         testsFailed++;
         $display("[TB] FAIL bp_count: got %0d expected 4", got.size());
      end else begin
         for (int i = 0; i < 4; i++) begin
            testsRun++;
            if (got[i] !== 8'h10 + W'(i)) begin testsFailed++; $display("[TB] FAIL bp_order: got %h expected %h", got[i], 8'h10 + W'(i)); end
         end
      end
   endtask

   task automatic test_bubble();
      logic [W-1:0] got[$];
      int gotEdge[$];
      out_rdy = 1'b1; in_val = 1'b0;
      repeat (5) advance();
      out_rdy = 1'b0;
      in_val = 1'b1; in_msg = 8'h20;
      @(negedge clk);
      testsRun++;
      if (in_rdy !== 1'b1) begin testsFailed++; $display("[TB] FAIL bubble_first_rdy: got %b expected 1", in_rdy); end
      advance();
      in_val = 1'b0;
      advance();
      advance();
      in_val = 1'b1; in_msg = 8'h21;
      @(negedge clk);
      testsRun++;
      if (in_rdy !== 1'b1) begin testsFailed++; $display("[TB] FAIL bubble_second_rdy: got %b expected 1", in_rdy); end
      advance();
      in_val = 1'b0;
      advance();
      advance();
      @(negedge clk);
      testsRun++;
      if (occupancy !== 2'd2) begin testsFailed++; $display("[TB] FAIL bubble_occ: got %0d expected 2", occupancy); end
      out_rdy = 1'b1;
      for (int c = 0; c < 6; c++) begin
         if (c > 0) @(negedge clk);
         predict();
         testsRun++;
         if (out_val !== expOutVal) begin testsFailed++; $display("[TB] FAIL bubble_out_val: got %b expected %b", out_val, expOutVal); end
         if (out_val === 1'b1) begin
            got.push_back(out_msg);
            gotEdge.push_back(cycle);
         end
         advance();
      end
      testsRun++;
      if (got.size() != 2) begin
         testsFailed++;
         $display("[TB] FAIL bubble_count: got %0d expected 2", got.size());
      end else begin
         testsRun++;
         if (got[0] !== 8'h20 || got[1] !== 8'h21) begin
            testsFailed++;
            $display("[TB] FAIL bubble_order: got %h,%h expected 20,21", got[0], got[1]);
         end
         testsRun++;
         if (gotEdge[1] - gotEdge[0] != 1) begin
            testsFailed++;
            $display("[TB] FAIL bubble_consecutive: got gap %0d expected 1", gotEdge[1] - gotEdge[0]);
         end
      end
   endtask

   task automatic test_reset_midstream();
      out_rdy = 1'b1; in_val = 1'b0;
      repeat (5) advance();
      out_rdy = 1'b0; in_val = 1'b1;
      in_msg = 8'h3C; advance();
      in_msg = 8'h3D; advance();
      in_val = 1'b0;
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      testsRun++;
      if (out_val !== 1'b0) begin testsFailed++; $display("[TB] FAIL midreset_out_val: got %b expected 0", out_val); end
      testsRun++;
      if (out_msg !== RV) begin testsFailed++; $display("[TB] FAIL midreset_out_msg: got %h expected %h", out_msg, RV); end
      testsRun++;
      if (occupancy !== 2'd0) begin testsFailed++; $display("[TB] FAIL midreset_occ: got %0d expected 0", occupancy); end
      #1 reset = 1'b0;
      mMsg.delete(); mPos.delete(); mLastEnd = RV;
      out_rdy = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         testsRun++;
         if (out_val !== 1'b0 || out_msg !== RV) begin
            testsFailed++;
            $display("[TB] FAIL midreset_ghost: got out_val=%b out_msg=%h expected 0/%h", out_val, out_msg, RV);
         end
         advance();
      end
   endtask

   task automatic test_random();
      logic [W-1:0] sb[$];
      int accN = 0;
      int drnN = 0;
      out_rdy = 1'b1; in_val = 1'b0;
      repeat (5) advance();
      for (int c = 0; c < 1000; c++) begin
         in_val  = 1'($urandom_range(0, 1));
         out_rdy = 1'($urandom_range(0, 1));
         in_msg  = W'($urandom);
         @(negedge clk);
         predict();
         testsRun++;
         if (in_rdy !== expInRdy) begin testsFailed++; $display("[TB] FAIL rand_in_rdy: cycle %0d got %b expected %b", cycle, in_rdy, expInRdy); end
         testsRun++;
         if (out_val !== expOutVal) begin testsFailed++; $display("[TB] FAIL rand_out_val: cycle %0d got %b expected %b", cycle, out_val, expOutVal); end
         testsRun++;
         if (out_msg !== expOutMsg) begin testsFailed++; $display("[TB] FAIL rand_out_msg: cycle %0d got %h expected %h", cycle, out_msg, expOutMsg); end
         testsRun++;
         if (int'(occupancy) != accN - drnN) begin testsFailed++; $display("[TB] FAIL rand_occ: cycle %0d got %0d expected %0d", cycle, occupancy, accN - drnN); end
         if (out_val === 1'b1 && out_rdy) begin
            drnN++;
            testsRun++;
            if (sb.size() == 0 || out_msg !== sb[0]) begin
               testsFailed++;
               $display("[TB] FAIL rand_scoreboard: cycle %0d got %h expected %h", cycle, out_msg, (sb.size() > 0) ? sb[0] : 8'h00);
            end
            if (sb.size() > 0) void'(sb.pop_front());
         end
         if (in_val && in_rdy === 1'b1) begin
            sb.push_back(in_msg);
            accN++;
         end
         advance();
      end
      in_val = 1'b0;
   endtask

`ifdef VC_ELASTIC_PIPE_FLUSH_EN
   task automatic test_flush();
      int   waitCycles = 0;
      logic seen = 1'b0;
      out_rdy = 1'b1; in_val = 1'b0;
      repeat (5) advance();
      out_rdy = 1'b0; in_val = 1'b1;
      for (int c = 0; c < 3; c++) begin
         in_msg = 8'h50 + W'(c);
         advance();
      end
      in_val = 1'b0;
      @(negedge clk);
      testsRun++;
      if (occupancy !== 2'd3) begin testsFailed++; $display("[TB] FAIL flush_pre_occ: got %0d expected 3", occupancy); end
      flush = 1'b1; in_val = 1'b1; in_msg = 8'h53; out_rdy = 1'b1;
      #1;
      testsRun++;
      if (in_rdy !== 1'b0) begin testsFailed++; $display("[TB] FAIL flush_in_rdy: got %b expected 0", in_rdy); end
      testsRun++;
      if (out_val !== 1'b0) begin testsFailed++; $display("[TB] FAIL flush_out_val: got %b expected 0", out_val); end
      advance();
      flush = 1'b0; in_msg = 8'h54;
      @(negedge clk);
      testsRun++;
      if (occupancy !== 2'd0) begin testsFailed++; $display("[TB] FAIL flush_post_occ: got %0d expected 0", occupancy); end
      advance();
      in_val = 1'b0;
      while (!seen && waitCycles < 10) begin
         @(negedge clk);
         if (out_val === 1'b1) begin
            seen = 1'b1;
            testsRun++;
            if (out_msg !== 8'h54) begin testsFailed++; $display("[TB] FAIL flush_next_msg: got %h expected 54", out_msg); end
            testsRun++;
            if (waitCycles != 2) begin testsFailed++; $display("[TB] FAIL flush_latency: got %0d expected 2", waitCycles); end
         end else begin
            waitCycles++;
         end
         advance();
      end
      if (!seen) begin
         testsRun++;
         testsFailed++;
         $display("[TB] FAIL flush_timeout: got no output expected 54");
      end
   endtask
`endif

   initial begin
      reset = 1'b0; flush = 1'b0; in_val = 1'b0; out_rdy = 1'b0; in_msg = '0;
      test_reset();
      test_streaming();
      test_backpressure();
      test_bubble();
      test_reset_midstream();
      test_random();
`ifdef VC_ELASTIC_PIPE_FLUSH_EN
      test_flush();
`endif
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
